// File: rtl/logic_unit_pkg.sv
// Shared constants, op encodings, FSM state encoding and a parity helper for the logic unit arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package logic_unit_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } lu_op_t;

    // Response buffer occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Odd-parity bit: 1 when an odd number of bits are set.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Bundles the two requester channels and the response channel of the logic unit arbiter.
// Latency: none (wiring only).
// Backpressure: req*_ready driven by the arbiter, resp_ready driven by the consumer.
// Ports: req0_*/req1_* valid/ready/op/a/b; resp_valid/ready/id/data/zero/parity/err.
// master = requesters + consumer side, slave = the arbiter.
import logic_unit_pkg::*;

interface logic_unit_arbiter_if;
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_data;
    logic              resp_zero;
    logic              resp_parity;
    logic              resp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_zero, resp_parity, resp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_zero, resp_parity, resp_err
    );
endinterface

// File: rtl/logic_unit_arbiter_lu.sv
// Combinational 8-bit logical unit: AND/OR/NOT/NAND/NOR/XOR/XNOR, reserved op yields zero.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: op (select), a, b (operands), y (result).
import logic_unit_pkg::*;

module logic_unit #(
    parameter int W   = DATA_W,
    parameter int OPW = OP_W
) (
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;          // b intentionally unused
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;          // reserved encoding
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logical unit between two requesters, with a one-entry response buffer.
// Latency: accept in cycle T, resp_valid from T+1; one op per cycle while resp_ready stays high.
// Backpressure: req*_ready only when the buffer is empty or being drained this cycle; never during rst.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying both request channels and the response.
import logic_unit_pkg::*;

module logic_unit_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              winner;
    logic              can_accept;
    logic              rdy0;
    logic              rdy1;
    logic              xfer;

    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] lu_y;

    logic              id_r;
    logic [DATA_W-1:0] data_r;
    logic              zero_r;
    logic              parity_r;
    logic              err_r;

    // Arbitration looks only at the current valids; last_grant breaks ties so
    // that two continuously valid requesters alternate.
    always_comb begin
        winner = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant;
        end else if (bus.req1_valid) begin
            winner = 1'b1;
        end
    end

    // Reset is folded in here so no handshake can complete during rst.
    assign can_accept = !rst && ((state == EMPTY) || ((state == FULL) && bus.resp_ready));
    assign rdy0       = can_accept && !winner && bus.req0_valid;
    assign rdy1       = can_accept &&  winner && bus.req1_valid;
    assign xfer       = rdy0 || rdy1;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;

    // Winner's operands feed the shared datapath.
    assign sel_op = winner ? bus.req1_op : bus.req0_op;
    assign sel_a  = winner ? bus.req1_a  : bus.req0_a;
    assign sel_b  = winner ? bus.req1_b  : bus.req0_b;

    logic_unit #(
        .W   (DATA_W),
        .OPW (OP_W)
    ) u_lu (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (lu_y)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (xfer) state_nxt = FULL;
            end
            FULL: begin
                // Drain with no refill empties the buffer; drain with refill
                // overwrites it in place for back-to-back throughput.
                if (bus.resp_ready && !xfer) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            data_r     <= '0;
            zero_r     <= 1'b0;
            parity_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                last_grant <= winner;
                id_r       <= winner;
                data_r     <= lu_y;
                zero_r     <= (lu_y == '0);
                parity_r   <= odd_parity(lu_y);
                err_r      <= (sel_op == OP_RSVD);
            end
        end
    end

    // Payload registers hold their last values after the buffer drains;
    // only resp_valid reflects occupancy.
    assign bus.resp_valid  = (state == FULL);
    assign bus.resp_id     = id_r;
    assign bus.resp_data   = data_r;
    assign bus.resp_zero   = zero_r;
    assign bus.resp_parity = parity_r;
    assign bus.resp_err    = err_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed, table-driven bench for logic_unit_arbiter plus hand-written reset-in-flight sequence.
// Latency: checks readies before each edge and response outputs 1 time unit after it.
// Backpressure: exercised via resp_ready low stretches with pending requests.
module tb_logic_unit_arbiter;

    logic clk;
    logic rst;

    logic_unit_arbiter_if bus ();

    logic_unit_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [2:0] op0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       v1;
        logic [2:0] op1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       rr;
        logic       e_r0;
        logic       e_r1;
        logic       e_rv;
        logic       e_id;
        logic [7:0] e_dat;
        logic       e_z;
        logic       e_p;
        logic       e_e;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks;
    int failures;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic rr);
        bus.req0_valid = v0;
        bus.req0_op    = op0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_op    = op1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.resp_ready = rr;
    endtask

    task automatic check_resp(input string tag, input logic rv, input logic id, input logic [7:0] dat,
                              input logic z, input logic p, input logic e);
        check({tag, "_rv"},  {7'd0, bus.resp_valid},  {7'd0, rv});
        check({tag, "_id"},  {7'd0, bus.resp_id},     {7'd0, id});
        check({tag, "_dat"}, bus.resp_data,           dat);
        check({tag, "_z"},   {7'd0, bus.resp_zero},   {7'd0, z});
        check({tag, "_p"},   {7'd0, bus.resp_parity}, {7'd0, p});
        check({tag, "_e"},   {7'd0, bus.resp_err},    {7'd0, e});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, "_r0"}, {7'd0, bus.req0_ready}, {7'd0, r0});
        check({tag, "_r1"}, {7'd0, bus.req1_ready}, {7'd0, r1});
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase of the next one.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.v0, v.op0, v.a0, v.b0, v.v1, v.op1, v.a1, v.b1, v.rr);
        #1;
        check_rdy(tag, v.e_r0, v.e_r1);
        @(posedge clk);
        #1;
        check_resp(tag, v.e_rv, v.e_id, v.e_dat, v.e_z, v.e_p, v.e_e);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            v0  op0   a0     b0     v1  op1   a1     b1     rr  r0  r1  rv  id  dat    z   p   e
        // Both valid from reset: grants 0,1,0,1.
        vecs[0]  = '{1'b1,3'd5,8'hAA,8'hFF, 1'b1,3'd1,8'h01,8'h02, 1'b1, 1'b1,1'b0, 1'b1,1'b0,8'h55, 1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,3'd5,8'hAA,8'hFF, 1'b1,3'd1,8'h01,8'h02, 1'b1, 1'b0,1'b1, 1'b1,1'b1,8'h03, 1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b1,3'd5,8'hAA,8'hFF, 1'b1,3'd1,8'h01,8'h02, 1'b1, 1'b1,1'b0, 1'b1,1'b0,8'h55, 1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,3'd5,8'hAA,8'hFF, 1'b1,3'd1,8'h01,8'h02, 1'b1, 1'b0,1'b1, 1'b1,1'b1,8'h03, 1'b0,1'b0,1'b0};
        // Single requester AND.
        vecs[4]  = '{1'b1,3'd0,8'hF0,8'h3C, 1'b0,3'd0,8'h00,8'h00, 1'b1, 1'b1,1'b0, 1'b1,1'b0,8'h30, 1'b0,1'b0,1'b0};
        // Stall 3 cycles with req1 pending, then release.
        vecs[5]  = '{1'b0,3'd0,8'h00,8'h00, 1'b1,3'd6,8'h0F,8'h0E, 1'b0, 1'b0,1'b0, 1'b1,1'b0,8'h30, 1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,3'd0,8'h00,8'h00, 1'b1,3'd6,8'h0F,8'h0E, 1'b0, 1'b0,1'b0, 1'b1,1'b0,8'h30, 1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,3'd0,8'h00,8'h00, 1'b1,3'd6,8'h0F,8'h0E, 1'b0, 1'b0,1'b0, 1'b1,1'b0,8'h30, 1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,3'd0,8'h00,8'h00, 1'b1,3'd6,8'h0F,8'h0E, 1'b1, 1'b0,1'b1, 1'b1,1'b1,8'hFE, 1'b0,1'b1,1'b0};
        // NOT ignores b; reserved op.
        vecs[9]  = '{1'b1,3'd2,8'hFF,8'h12, 1'b0,3'd0,8'h00,8'h00, 1'b1, 1'b1,1'b0, 1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0,3'd0,8'h00,8'h00, 1'b1,3'd7,8'h5A,8'hA5, 1'b1, 1'b0,1'b1, 1'b1,1'b1,8'h00, 1'b1,1'b0,1'b1};
        // Drain to EMPTY, payload holds; idle EMPTY.
        vecs[11] = '{1'b0,3'd0,8'h00,8'h00, 1'b0,3'd0,8'h00,8'h00, 1'b1, 1'b0,1'b0, 1'b0,1'b1,8'h00, 1'b1,1'b0,1'b1};
        vecs[12] = '{1'b0,3'd0,8'h00,8'h00, 1'b0,3'd0,8'h00,8'h00, 1'b0, 1'b0,1'b0, 1'b0,1'b1,8'h00, 1'b1,1'b0,1'b1};
        // EMPTY accepts even with resp_ready low; NAND.
        vecs[13] = '{1'b1,3'd3,8'hF0,8'h3C, 1'b0,3'd0,8'h00,8'h00, 1'b0, 1'b1,1'b0, 1'b1,1'b0,8'hCF, 1'b0,1'b0,1'b0};
        // FULL and stalled: NOR waits, then goes.
        vecs[14] = '{1'b1,3'd4,8'h0F,8'hF0, 1'b0,3'd0,8'h00,8'h00, 1'b0, 1'b0,1'b0, 1'b1,1'b0,8'hCF, 1'b0,1'b0,1'b0};
        vecs[15] = '{1'b1,3'd4,8'h0F,8'hF0, 1'b0,3'd0,8'h00,8'h00, 1'b1, 1'b1,1'b0, 1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0};
        // Both valid but stalled: nothing granted, outputs hold.
        vecs[16] = '{1'b1,3'd5,8'hAA,8'hFF, 1'b1,3'd1,8'h01,8'h02, 1'b0, 1'b0,1'b0, 1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0};
        // Release: last grant was 0, so requester 1 wins; XNOR result.
        vecs[17] = '{1'b1,3'd5,8'hAA,8'hFF, 1'b1,3'd6,8'h0F,8'h0E, 1'b1, 1'b0,1'b1, 1'b1,1'b1,8'hFE, 1'b0,1'b1,1'b0};

        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_rdy("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_resp("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        // Reset with buffer FULL and req0 pending: no handshake, buffer discarded.
        drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        check_rdy("mrst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_resp("mrst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // First contention after reset goes to requester 0, then alternates.
        drive(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b1, 3'd1, 8'h01, 8'h02, 1'b1);
        #1;
        check_rdy("post0", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_resp("post0", 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        #1;
        check_rdy("post1", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_resp("post1", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares the single 8-bit logical unit between two requesters, e.g. the execute stage and the flag/compare micro-sequencer. Arbitrates round-robin and issues the winning operands and op select to the logical unit. Registers the result into a one-entry response buffer with a valid/ready handshake, a requester tag and status flags. Sustains one operation per cycle when the consumer does not stall.

Parameters:
DATA_W, 8, operand/result width
OP_W, 3, logical op select width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  OP_W  op select: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved
req0_a  input  DATA_W  operand a
req0_b  input  DATA_W  operand b
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
resp_valid  output  1  response buffer full
resp_ready  input  1  consumer takes the response this cycle
resp_id  output  1  index of the requester that issued the result
resp_data  output  DATA_W  logical result
resp_zero  output  1  resp_data == 0
resp_parity  output  1  XOR-reduce of resp_data (odd parity)
resp_err  output  1  op was 7 (reserved); resp_data = 0

Behaviour:
- One clock; reset is synchronous and active-high. On rst=1 at a clk edge the block enters state EMPTY:
  - resp_valid=0; resp_id=0; resp_data=0; resp_zero=0; resp_parity=0; resp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
- rst=1 mid-operation discards any buffered response. No handshake completes in a cycle where rst=1: req*_ready is forced to 0.
- can_accept = (state==EMPTY) | (state==FULL & resp_ready).
- Arbitration is combinational on the current valids:
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
  - Neither valid: no grant.
- reqN_ready = can_accept & winner==N & reqN_valid. Ready may depend on valid. Requesters must not make valid depend on ready.
- Transfer = valid & ready for a requester. On a transfer edge:
  - Winner's op/a/b drive the logical unit combinationally.
  - Result is captured into resp_data. resp_id=winner. resp_zero, resp_parity and resp_err are computed from the captured values.
  - last_grant=winner.
- Latency: accept in cycle T -> resp_valid=1 from cycle T+1.
- States:
  - EMPTY: transfer -> FULL; otherwise stay EMPTY.
  - FULL, resp_ready=0: hold. All resp_* outputs stay stable and both readies are 0.
  - FULL, resp_ready=1 with a transfer in the same cycle: the buffer is overwritten with the new result; stay FULL. This gives back-to-back throughput.
  - FULL, resp_ready=1 with no transfer: go to EMPTY. resp_valid=0; other resp_* outputs hold their last values.
- Op 2 ignores operand b. Op 7 returns data 0 with zero=1, parity=0, err=1, and is otherwise a normal transfer.
- last_grant does not change when there is no transfer.
- Starvation bound: with both requesters continuously valid, grants strictly alternate.

Decomposition:
- Shared package logic_unit_pkg holds:
  - Constants DATA_W=8 and OP_W=3.
  - Op encodings: OP_AND=0, OP_OR=1, OP_NOT=2, OP_NAND=3, OP_NOR=4, OP_XOR=5, OP_XNOR=6, OP_RSVD=7.
  - State encoding EMPTY/FULL.
- One sub-module: the existing combinational logical unit, instantiated unchanged as the datapath. The arbiter holds only muxing, FSM, flags and the buffer.

Test Plan:
- Reset, then req0 valid op=0 a=8'hF0 b=8'h3C, resp_ready=1 -> req0_ready=1 in cycle T. In T+1: resp_valid=1, resp_id=0, resp_data=8'h30, zero=0, parity=0, err=0.
- Both valid from reset, req0 op=5 a=8'hAA b=8'hFF, req1 op=1 a=8'h01 b=8'h02, resp_ready=1 -> grants alternate 0,1,0,1. Responses alternate 8'h55 (id 0) and 8'h03 (id 1), one per cycle.
- Stall: buffer FULL with 8'h30, resp_ready=0 for 3 cycles while req1 is valid -> req1_ready=0 and resp outputs unchanged. When resp_ready=1, req1 transfers in that cycle and the new result appears next cycle.
- Op 2 a=8'hFF b=8'h12 -> resp_data=8'h00, zero=1. Op 7 a=8'h5A b=8'hA5 -> resp_data=8'h00, err=1, zero=1.
- Reset mid-operation: buffer FULL and req0 valid, assert rst for 1 cycle -> req0_ready=0 that cycle. Next cycle resp_valid=0 and all resp_* outputs are 0. After rst drops, req0 wins the first contention.
- Op 6 a=8'h0F b=8'h0E -> resp_data=8'hFE, parity=1, zero=0.
